loba_mul_pipe: RTL and testbench
================================

Name: loba_mul_pipe

Overview:
Pipelined, parametrised leading-one-based approximate (LOBA) multiplier with a run-time accuracy mode. Each operand is split at its leading one into a K-bit high segment and a low remainder. The product is built from the selected partial products.
Sits in the datapath between operand producers and accumulators. It uses a valid/ready stream on each side with full backpressure, and carries an opaque tag alongside each product.

Parameters:
N, 16, operand width (N >= K+1)
K, 4, high-segment width (K >= 2)
TAG_W, 4, width of sideband tag passed through with each operation

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operands present
in_ready  out  1  block can accept this cycle
in_a  in  N  operand A
in_b  in  N  operand B
in_mode  in  2  0=LOBA0, 1=LOBA1, 2/3=exact
in_tag  in  TAG_W  sideband, returned unchanged
out_valid  out  1  product present
out_ready  in  1  consumer accepts
out_p  out  2N  product
out_tag  out  TAG_W  tag of this product
out_mode  out  2  mode of this product

Behaviour:
- Single clock (clk). Reset is synchronous and active-high (rst). All stage valids clear on reset; out_valid=0, out_p=0, out_tag=0, out_mode=0. in_ready=1 in the first cycle after reset.
- Split of X, per operand:
  - p = index of the leading one (p=0 if X=0).
  - k = max(p-K+1, 0).
  - Xh = X>>k, which is K bits.
  - Xl = X & (2^k-1).
  - Identity: X = Xh*2^k + Xl.
- Products, full 2N-bit precision with no overflow:
  - mode 0: P = (Ah*Bh) << (ka+kb).
  - mode 1: P = mode0 + (Ah*Bl)<<ka + (Al*Bh)<<kb.
  - mode 2/3: P = mode1 + Al*Bl. This equals A*B exactly.
- If both operands are below 2^(K-1) then k=0 and every mode is exact.
- Pipeline has 3 stages:
  - S1: register the split (Ah, Al, ka, kb, mode, tag).
  - S2: register the four partial products plus the shift amounts.
  - S3: shift, masked sum by mode, register to out_p.
- Latency is 3 cycles from the in_valid&in_ready edge to out_valid, when there is no stall.
- Handshake:
  - Transfer occurs on valid&ready.
  - A stage advances when it is empty or the next stage advances.
  - in_ready = !S1_valid | S1 advances. Combinational from out_ready only.
  - Holding out_ready=0 stalls all stages. out_p, out_tag and out_mode are held stable while out_valid&!out_ready.
  - Up to 3 operations are in flight. No loss, no duplication, strict in-order completion.
- Simultaneous accept and emit in the same cycle sustains a throughput of 1 per cycle.
- in_mode is sampled per operation. Mixed modes in flight are legal.
- rst asserted mid-stream discards all in-flight operations. No output appears for them.

Optional Feature:
- Macro LOBA_SIGNED_EN.
- Defined:
  - in_a and in_b are two's complement.
  - S1 takes the magnitudes. -2^(N-1) is represented as N-bit unsigned 2^(N-1).
  - The sign is A[N-1]^B[N-1], carried through the pipe.
  - S3 negates P when the sign is 1 and P is nonzero.
  - out_p is two's complement.
- Undefined: operands are unsigned, with no sign logic. Latency is unchanged in both builds.

Decomposition:
- Package loba_pkg:
  - mode constants LOBA_MODE_L0=0, LOBA_MODE_L1=1, LOBA_MODE_EXACT=2.
  - width function for the shift field, $clog2(N).
- Sub-module loba_lod_split (parameters N, K):
  - Combinational leading-one detector plus segment extractor.
  - Ports X, Xh, Xl, k.
  - One instance per operand in S1.

Test Plan:
- A=0x00FF, B=0x0013, N=16, K=4, one operation per mode (ka=4, Ah=15, Al=15, kb=1, Bh=9, Bl=1):
  - mode0 -> out_p=4320.
  - mode1 -> 4830.
  - mode2 -> 4845.
  - Each arrives exactly 3 cycles after acceptance.
- A=5, B=3 in all modes -> 15. A=0 with B=0xFFFF -> 0.
- A=B=0xFFFF:
  - mode0 -> 0xE1000000.
  - mode2 -> 0xFFFE0001.
- Backpressure:
  - Hold out_ready=0 and offer 5 back-to-back operations with tags 1..5.
  - in_ready drops after 3 are accepted, and out_p/out_tag are held.
  - Release out_ready: tags emerge in order 1..5, one per cycle, with none lost.
- Reset with 3 operations in flight, plus one accepted in the same cycle -> next cycle out_valid=0, and no stale product ever appears.
- LOBA_SIGNED_EN, A=0xFF01 (-255), B=19:
  - mode0 -> 0xFFFFEF20 (-4320).
  - mode2 -> -4845.
  - A=0x8000, B=1, exact -> 0xFFFF8000.

Source files
------------

// File: rtl/loba_mul_pipe_pkg.sv
// Shared constants and helpers for the LOBA multiplier pipeline.
// Build option LOBA_SIGNED_EN (two's-complement mode) is handled in loba_mul_pipe.
package loba_pkg;

  localparam logic [1:0] LOBA_MODE_L0    = 2'd0;
  localparam logic [1:0] LOBA_MODE_L1    = 2'd1;
  localparam logic [1:0] LOBA_MODE_EXACT = 2'd2;

  // Width of a per-operand shift field; the largest shift is N-K, always below N.
  function automatic int loba_shift_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/loba_mul_pipe_if.sv
// Valid/ready operand and product streams of loba_mul_pipe.
// master drives operands and consumes products; slave is the multiplier.
interface loba_mul_pipe_if #(
  parameter int N     = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   out_p;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_mode;

  modport master (
    output in_valid, in_a, in_b, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag, out_mode
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag, out_mode
  );
endinterface

// File: rtl/loba_mul_pipe_lod_split.sv
// Leading-one detector and segment extractor: X = Xh*2^k + Xl, Xh is K bits.
// Purely combinational; one instance per operand in the first stage.
module loba_lod_split
  import loba_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 4,
  localparam int KW = loba_shift_w(N)
) (
  input  logic [N-1:0]  X,
  output logic [K-1:0]  Xh,
  output logic [N-1:0]  Xl,
  output logic [KW-1:0] k
);
  logic [KW-1:0] p_s;

  // Position of the highest set bit, 0 for a zero operand.
  always_comb begin
    p_s = '0;
    for (int i = 0; i < N; i++) begin
      if (X[i]) begin
        p_s = KW'(i);
      end else begin
        p_s = p_s;
      end
    end
  end

  // Shift so the leading one lands in the top bit of the K-bit segment.
  always_comb begin
    if (p_s >= KW'(K - 1)) begin
      k = p_s - KW'(K - 1);
    end else begin
      k = '0;
    end
  end

  assign Xh = K'(X >> k);
  assign Xl = X & ~({N{1'b1}} << k);

endmodule

// File: rtl/loba_mul_pipe.sv
// Three-stage LOBA approximate multiplier with per-operation accuracy mode and tag.
// Define LOBA_SIGNED_EN for two's-complement operands and product.
module loba_mul_pipe
  import loba_pkg::*;
#(
  parameter int N     = 16,
  parameter int K     = 4,
  parameter int TAG_W = 4
) (
  input logic            clk,
  input logic            rst,
  loba_mul_pipe_if.slave bus
);
  localparam int KW = loba_shift_w(N);
  localparam int SW = KW + 1;
  localparam int PW = 2 * N;
  localparam int HW = 2 * K;
  localparam int XW = N + K;

  logic             adv1_s, adv2_s, adv3_s;
  logic [N-1:0]     a_mag_s, b_mag_s;
  logic [K-1:0]     ah_s, bh_s;
  logic [N-1:0]     al_s, bl_s;
  logic [KW-1:0]    ka_s, kb_s;

  logic             v1_r;
  logic [K-1:0]     ah1_r, bh1_r;
  logic [N-1:0]     al1_r, bl1_r;
  logic [KW-1:0]    ka1_r, kb1_r;
  logic [1:0]       mode1_r;
  logic [TAG_W-1:0] tag1_r;

  logic             v2_r;
  logic [HW-1:0]    hh2_r;
  logic [XW-1:0]    hl2_r, lh2_r;
  logic [PW-1:0]    ll2_r;
  logic [KW-1:0]    ka2_r, kb2_r;
  logic [1:0]       mode2_r;
  logic [TAG_W-1:0] tag2_r;

  logic             v3_r;
  logic [PW-1:0]    p3_r;
  logic [TAG_W-1:0] tag3_r;
  logic [1:0]       mode3_r;

  logic [SW-1:0]    shamt_s;
  logic [PW-1:0]    hh_sh_s, cross_s, sum_s, p_next_s;

  // A stage moves when it is empty or its successor moves; full stall from out_ready.
  assign adv3_s       = ~v3_r | bus.out_ready;
  assign adv2_s       = ~v2_r | adv3_s;
  assign adv1_s       = ~v1_r | adv2_s;
  assign bus.in_ready = adv1_s;

`ifdef LOBA_SIGNED_EN
  logic sign_s, sign1_r, sign2_r;

  // Magnitudes feed the split; the most negative value maps to unsigned 2^(N-1).
  always_comb begin
    if (bus.in_a[N-1]) begin
      a_mag_s = ~bus.in_a + N'(1);
    end else begin
      a_mag_s = bus.in_a;
    end
    if (bus.in_b[N-1]) begin
      b_mag_s = ~bus.in_b + N'(1);
    end else begin
      b_mag_s = bus.in_b;
    end
    sign_s = bus.in_a[N-1] ^ bus.in_b[N-1];
  end

  // Product sign travels with the operation through S1 and S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign1_r <= 1'b0;
      sign2_r <= 1'b0;
    end else begin
      if (adv1_s) sign1_r <= sign_s;
      if (adv2_s) sign2_r <= sign1_r;
    end
  end
`else
  assign a_mag_s = bus.in_a;
  assign b_mag_s = bus.in_b;
`endif

  loba_lod_split #(.N(N), .K(K)) u_split_a (
    .X  (a_mag_s),
    .Xh (ah_s),
    .Xl (al_s),
    .k  (ka_s)
  );

  loba_lod_split #(.N(N), .K(K)) u_split_b (
    .X  (b_mag_s),
    .Xh (bh_s),
    .Xl (bl_s),
    .k  (kb_s)
  );

  // S1: register operand segments, shifts, mode and tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r    <= 1'b0;
      ah1_r   <= '0;
      bh1_r   <= '0;
      al1_r   <= '0;
      bl1_r   <= '0;
      ka1_r   <= '0;
      kb1_r   <= '0;
      mode1_r <= LOBA_MODE_L0;
      tag1_r  <= '0;
    end else if (adv1_s) begin
      v1_r    <= bus.in_valid;
      ah1_r   <= ah_s;
      bh1_r   <= bh_s;
      al1_r   <= al_s;
      bl1_r   <= bl_s;
      ka1_r   <= ka_s;
      kb1_r   <= kb_s;
      mode1_r <= bus.in_mode;
      tag1_r  <= bus.in_tag;
    end
  end

  // S2: register the four partial products; all are formed regardless of mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r    <= 1'b0;
      hh2_r   <= '0;
      hl2_r   <= '0;
      lh2_r   <= '0;
      ll2_r   <= '0;
      ka2_r   <= '0;
      kb2_r   <= '0;
      mode2_r <= LOBA_MODE_L0;
      tag2_r  <= '0;
    end else if (adv2_s) begin
      v2_r    <= v1_r;
      hh2_r   <= HW'(ah1_r) * HW'(bh1_r);
      hl2_r   <= XW'(ah1_r) * XW'(bl1_r);
      lh2_r   <= XW'(al1_r) * XW'(bh1_r);
      ll2_r   <= PW'(al1_r) * PW'(bl1_r);
      ka2_r   <= ka1_r;
      kb2_r   <= kb1_r;
      mode2_r <= mode1_r;
      tag2_r  <= tag1_r;
    end
  end

  // S3 datapath: align partial products and keep those the mode selects.
  always_comb begin
    shamt_s = SW'(ka2_r) + SW'(kb2_r);
    hh_sh_s = PW'(hh2_r) << shamt_s;
    cross_s = (PW'(hl2_r) << ka2_r) + (PW'(lh2_r) << kb2_r);
    case (mode2_r)
      LOBA_MODE_L0:    sum_s = hh_sh_s;
      LOBA_MODE_L1:    sum_s = hh_sh_s + cross_s;
      LOBA_MODE_EXACT: sum_s = hh_sh_s + cross_s + ll2_r;
      default:         sum_s = hh_sh_s + cross_s + ll2_r;
    endcase
  end

`ifdef LOBA_SIGNED_EN
  // Apply the carried sign; a zero product stays zero.
  always_comb begin
    if (sign2_r && (sum_s != '0)) begin
      p_next_s = ~sum_s + PW'(1);
    end else begin
      p_next_s = sum_s;
    end
  end
`else
  assign p_next_s = sum_s;
`endif

  // S3: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_r    <= 1'b0;
      p3_r    <= '0;
      tag3_r  <= '0;
      mode3_r <= LOBA_MODE_L0;
    end else if (adv3_s) begin
      v3_r    <= v2_r;
      p3_r    <= p_next_s;
      tag3_r  <= tag2_r;
      mode3_r <= mode2_r;
    end
  end

  assign bus.out_valid = v3_r;
  assign bus.out_p     = p3_r;
  assign bus.out_tag   = tag3_r;
  assign bus.out_mode  = mode3_r;

endmodule

// File: tb/tb_loba_mul_pipe.sv
// Self-checking bench for loba_mul_pipe: directed vectors, backpressure, mid-stream reset
// and randomized traffic against an arithmetic reference model (honours LOBA_SIGNED_EN).
module tb_loba_mul_pipe;
  localparam int N     = 16;
  localparam int K     = 4;
  localparam int TAG_W = 4;
  localparam int PW    = 2 * N;

  typedef struct {
    logic [PW-1:0]    p;
    logic [TAG_W-1:0] tag;
    logic [1:0]       mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  loba_mul_pipe_if #(.N(N), .TAG_W(TAG_W)) bus ();

  loba_mul_pipe #(.N(N), .K(K), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: split at the leading one with plain arithmetic, sum the selected partial products.
  function automatic logic [PW-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [1:0] mode);
    longint unsigned ma, mb, ah, al, bh, bl, p;
    int ka, kb;
    bit neg;
    logic [63:0] r;
    ma  = 64'(a);
    mb  = 64'(b);
    neg = 1'b0;
`ifdef LOBA_SIGNED_EN
    if (a[N-1]) ma = (64'd1 << N) - 64'(a);
    if (b[N-1]) mb = (64'd1 << N) - 64'(b);
    neg = a[N-1] ^ b[N-1];
`endif
    ka = 0;
    while ((ma >> ka) >= (64'd1 << K)) ka++;
    kb = 0;
    while ((mb >> kb) >= (64'd1 << K)) kb++;
    ah = ma >> ka;
    al = ma - (ah << ka);
    bh = mb >> kb;
    bl = mb - (bh << kb);
    p = (ah * bh) << (ka + kb);
    if (mode != 2'd0) p = p + ((ah * bl) << ka) + ((al * bh) << kb);
    if (mode >= 2'd2) p = p + al * bl;
    if (neg && p != 64'd0) p = (64'd1 << PW) - p;
    r = p;
    return r[PW-1:0];
  endfunction

  function automatic logic [N-1:0] rand_operand();
    logic [N-1:0] v;
    case ($urandom_range(0, 4))
      0: v = N'($urandom_range(0, 7));
      1: v = 16'hFFFF;
      2: v = 16'h8000;
      3: v = N'($urandom_range(0, 255));
      default: v = N'($urandom);
    endcase
    return v;
  endfunction

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_mode   = 2'd0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_p !== '0) begin errors++; $display("FAIL reset_out_p got %0h want 0", bus.out_p); end
    checks++; if (bus.out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %0h want 0", bus.out_tag); end
    checks++; if (bus.out_mode !== 2'd0) begin errors++; $display("FAIL reset_out_mode got %0d want 0", bus.out_mode); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [N-1:0]  va[11];
    logic [N-1:0]  vb[11];
    logic [1:0]    vm[11];
    logic [PW-1:0] vp[11];
    int nv;
    int edges;
`ifdef LOBA_SIGNED_EN
    nv = 5;
    va[0] = 16'hFF01; vb[0] = 16'h0013; vm[0] = 2'd0; vp[0] = 32'hFFFFEF20;
    va[1] = 16'hFF01; vb[1] = 16'h0013; vm[1] = 2'd2; vp[1] = 32'hFFFFED13;
    va[2] = 16'h8000; vb[2] = 16'h0001; vm[2] = 2'd2; vp[2] = 32'hFFFF8000;
    va[3] = 16'h0005; vb[3] = 16'h0003; vm[3] = 2'd1; vp[3] = 32'd15;
    va[4] = 16'h0000; vb[4] = 16'hFFFF; vm[4] = 2'd2; vp[4] = 32'd0;
`else
    nv = 11;
    va[0]  = 16'h00FF; vb[0]  = 16'h0013; vm[0]  = 2'd0; vp[0]  = 32'd4320;
    va[1]  = 16'h00FF; vb[1]  = 16'h0013; vm[1]  = 2'd1; vp[1]  = 32'd4830;
    va[2]  = 16'h00FF; vb[2]  = 16'h0013; vm[2]  = 2'd2; vp[2]  = 32'd4845;
    va[3]  = 16'h0005; vb[3]  = 16'h0003; vm[3]  = 2'd0; vp[3]  = 32'd15;
    va[4]  = 16'h0005; vb[4]  = 16'h0003; vm[4]  = 2'd1; vp[4]  = 32'd15;
    va[5]  = 16'h0005; vb[5]  = 16'h0003; vm[5]  = 2'd2; vp[5]  = 32'd15;
    va[6]  = 16'h0005; vb[6]  = 16'h0003; vm[6]  = 2'd3; vp[6]  = 32'd15;
    va[7]  = 16'h0000; vb[7]  = 16'hFFFF; vm[7]  = 2'd0; vp[7]  = 32'd0;
    va[8]  = 16'h0000; vb[8]  = 16'hFFFF; vm[8]  = 2'd2; vp[8]  = 32'd0;
    va[9]  = 16'hFFFF; vb[9]  = 16'hFFFF; vm[9]  = 2'd0; vp[9]  = 32'hE1000000;
    va[10] = 16'hFFFF; vb[10] = 16'hFFFF; vm[10] = 2'd2; vp[10] = 32'hFFFE0001;
`endif
    for (int i = 0; i < nv; i++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = va[i];
      bus.in_b      = vb[i];
      bus.in_mode   = vm[i];
      bus.in_tag    = TAG_W'(i);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready[%0d] got %0b want 1", i, bus.in_ready); end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      edges = 1;
      while (bus.out_valid !== 1'b1 && edges < 10) begin
        @(posedge clk); #1;
        edges++;
      end
      checks++; if (edges != 3) begin errors++; $display("FAIL dir_latency[%0d] got %0d want 3", i, edges); end
      checks++; if (bus.out_p !== vp[i]) begin errors++; $display("FAIL dir_p[%0d] got %0h want %0h", i, bus.out_p, vp[i]); end
      checks++; if (bus.out_p !== ref_mul(va[i], vb[i], vm[i])) begin errors++; $display("FAIL dir_model[%0d] got %0h want %0h", i, bus.out_p, ref_mul(va[i], vb[i], vm[i])); end
      checks++; if (bus.out_tag !== TAG_W'(i) || bus.out_mode !== vm[i]) begin errors++; $display("FAIL dir_side[%0d] got tag %0d mode %0d want tag %0d mode %0d", i, bus.out_tag, bus.out_mode, i, vm[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] oa[5];
    logic [N-1:0] ob[5];
    logic [1:0]   om[5];
    int accepted, emitted, first_c, last_c;
    bit acc;
    for (int i = 0; i < 5; i++) begin
      oa[i] = rand_operand();
      ob[i] = rand_operand();
      om[i] = 2'($urandom_range(0, 3));
    end
    bus.out_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = oa[accepted];
      bus.in_b     = ob[accepted];
      bus.in_mode  = om[accepted];
      bus.in_tag   = TAG_W'(accepted + 1);
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) accepted++;
    end
    checks++; if (accepted != 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", accepted); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b want 0", bus.in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== TAG_W'(1) || bus.out_p !== ref_mul(oa[0], ob[0], om[0]))
        begin errors++; $display("FAIL bp_hold[%0d] got v %0b tag %0d p %0h want v 1 tag 1 p %0h", c, bus.out_valid, bus.out_tag, bus.out_p, ref_mul(oa[0], ob[0], om[0])); end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    emitted = 0;
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < 20 && emitted < 5; c++) begin
      if (accepted < 5) begin
        bus.in_valid = 1'b1;
        bus.in_a     = oa[accepted];
        bus.in_b     = ob[accepted];
        bus.in_mode  = om[accepted];
        bus.in_tag   = TAG_W'(accepted + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready;
      if (bus.out_valid === 1'b1) begin
        checks++; if (bus.out_tag !== TAG_W'(emitted + 1) || bus.out_p !== ref_mul(oa[emitted], ob[emitted], om[emitted]))
          begin errors++; $display("FAIL bp_order[%0d] got tag %0d p %0h want tag %0d p %0h", emitted, bus.out_tag, bus.out_p, emitted + 1, ref_mul(oa[emitted], ob[emitted], om[emitted])); end
        if (first_c < 0) first_c = c;
        last_c = c;
        emitted++;
      end
      @(posedge clk); #1;
      if (acc) accepted++;
    end
    bus.in_valid = 1'b0;
    checks++; if (emitted != 5) begin errors++; $display("FAIL bp_count got %0d want 5", emitted); end
    checks++; if (last_c - first_c != 4) begin errors++; $display("FAIL bp_rate got span %0d want 4", last_c - first_c); end
  endtask

  task automatic test_reset_midstream();
    int stale;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = rand_operand();
      bus.in_b     = rand_operand();
      bus.in_mode  = 2'($urandom_range(0, 3));
      bus.in_tag   = TAG_W'(i + 8);
      if (i == 3) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %0b want 1", bus.in_ready); end
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale got %0d outputs want 0", stale); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    exp_t got;
    bit acc, em;
    int emitted;
    emitted = 0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_a     = rand_operand();
        bus.in_b     = rand_operand();
        bus.in_mode  = 2'($urandom_range(0, 3));
        bus.in_tag   = TAG_W'($urandom);
      end
      bus.out_ready = (c >= 580) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (c >= 580) bus.in_valid = 1'b0;
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready;
      em  = bus.out_valid & bus.out_ready;
      if (em) begin
        got.p = bus.out_p; got.tag = bus.out_tag; got.mode = bus.out_mode;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_spurious got tag %0d p %0h want no output", got.tag, got.p);
        end else begin
          e = q.pop_front();
          checks++; if (got.p !== e.p || got.tag !== e.tag || got.mode !== e.mode)
            begin errors++; $display("FAIL rnd_out[%0d] got p %0h tag %0d mode %0d want p %0h tag %0d mode %0d", emitted, got.p, got.tag, got.mode, e.p, e.tag, e.mode); end
          emitted++;
        end
      end
      if (acc) begin
        e.p = ref_mul(bus.in_a, bus.in_b, bus.in_mode);
        e.tag = bus.in_tag;
        e.mode = bus.in_mode;
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending want 0", q.size()); end
    checks++; if (emitted < 50) begin errors++; $display("FAIL rnd_volume got %0d products want at least 50", emitted); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
